// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: segment codes, time-bus field
// positions and the display page type.
package fnd_pkg;

  // Active-low {g,f,e,d,c,b,a}; the dp bit is added by the controller.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int HOUR_MSB = 23;
  localparam int HOUR_LSB = 19;
  localparam int MIN_MSB  = 18;
  localparam int MIN_LSB  = 13;
  localparam int SEC_MSB  = 12;
  localparam int SEC_LSB  = 7;
  localparam int MSEC_MSB = 6;
  localparam int MSEC_LSB = 0;

  typedef enum logic {
    PAGE_SEC_MSEC = 1'b0,
    PAGE_HOUR_MIN = 1'b1
  } page_e;

  function automatic logic [3:0] tens_of(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Converts one decimal digit plus dash/blank flags into active-low 7-segment data.
module bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit common-anode 7-segment scanner for the packed 24-bit time bus.
// Optional FND_LEADING_ZERO_BLANK_EN blanks the leftmost digit when its tens value is zero.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_time,
  input  logic        sw0,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int DIV_W    = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             scan_tick;
  logic             tick_d;
  logic [1:0]       digit_sel;
  logic [23:0]      snap_time;
  page_e            snap_page;

  logic [6:0] snap_hour, snap_min, snap_sec, snap_msec;
  logic [6:0] pair_val;
  logic       pair_dash;
  logic [3:0] digit_val;
  logic       digit_blank;
  logic       dp_on;
  logic [6:0] seg;

  assign scan_tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

  // Input and page are captured only as the frame wraps back to digit 0, so a frame never mixes two times.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      tick_d    <= 1'b0;
      digit_sel <= 2'd0;
      snap_time <= '0;
      snap_page <= PAGE_SEC_MSEC;
    end else begin
      div_cnt <= scan_tick ? '0 : div_cnt + 1'b1;
      tick_d  <= scan_tick;
      if (scan_tick) begin
        digit_sel <= digit_sel + 2'd1;
        if (digit_sel == 2'd3) begin
          snap_time <= i_time;
          snap_page <= page_e'(sw0);
        end
      end
    end
  end

  assign snap_hour = {2'b00, snap_time[HOUR_MSB:HOUR_LSB]};
  assign snap_min  = {1'b0,  snap_time[MIN_MSB:MIN_LSB]};
  assign snap_sec  = {1'b0,  snap_time[SEC_MSB:SEC_LSB]};
  assign snap_msec = snap_time[MSEC_MSB:MSEC_LSB];

  always_comb begin
    pair_val = snap_msec;
    case ({digit_sel[1], snap_page})
      {1'b0, PAGE_SEC_MSEC}: pair_val = snap_msec;
      {1'b0, PAGE_HOUR_MIN}: pair_val = snap_min;
      {1'b1, PAGE_SEC_MSEC}: pair_val = snap_sec;
      {1'b1, PAGE_HOUR_MIN}: pair_val = snap_hour;
      default:               pair_val = snap_msec;
    endcase
  end

  assign pair_dash = (pair_val > 7'd99);
  assign digit_val = digit_sel[0] ? tens_of(pair_val) : ones_of(pair_val);
  assign dp_on     = (digit_sel == 2'd2) && (snap_msec < 7'd50);

`ifdef FND_LEADING_ZERO_BLANK_EN
  assign digit_blank = (digit_sel == 2'd3) && (tens_of(pair_val) == 4'd0) && !pair_dash;
`else
  assign digit_blank = 1'b0;
`endif

  bcd_to_seg u_bcd_to_seg (
    .value (digit_val),
    .dash  (pair_dash),
    .blank (digit_blank),
    .seg   (seg)
  );

  // Outputs follow the tick by one cycle, so they see the already-advanced digit_sel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
    end else if (tick_d) begin
      fnd_com  <= ~(4'b0001 << digit_sel);
      fnd_data <= {~dp_on, seg};
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller with SCAN_DIV=4 (CLK_HZ=4000, SCAN_HZ=1000).
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] i_time;
  logic        sw0;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  fnd_scan_controller #(.CLK_HZ(4000), .SCAN_HZ(1000)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_time   (i_time),
    .sw0      (sw0),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data)
  );

  function automatic logic [23:0] mk_time(input int hour, input int minute, input int sec, input int msec);
    return {5'(hour), 6'(minute), 6'(sec), 7'(msec)};
  endfunction

  function automatic logic [7:0] seg_of(input int v);
    case (v)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected {fnd_com, fnd_data} for digit d of a frame showing time t on the given page.
  function automatic logic [11:0] expect_digit(input logic [23:0] t, input logic page, input int d);
    int hour, minute, sec, msec, pair;
    logic [7:0] data;
    logic [3:0] com;
    hour   = int'(t[23:19]);
    minute = int'(t[18:13]);
    sec    = int'(t[12:7]);
    msec   = int'(t[6:0]);
    if (d >= 2) pair = page ? hour : sec;
    else        pair = page ? minute : msec;
    if (pair > 99) begin
      data = 8'hBF;
    end else begin
      data = seg_of((d % 2 == 1) ? pair / 10 : pair % 10);
`ifdef FND_LEADING_ZERO_BLANK_EN
      if (d == 3 && pair / 10 == 0) data = 8'hFF;
`endif
    end
    if (d == 2 && msec < 50) data[7] = 1'b0;
    com = 4'b1111;
    com[d] = 1'b0;
    return {com, data};
  endfunction

  task automatic push_frame(input logic [23:0] t, input logic page);
    for (int d = 0; d < 4; d++) exp_q.push_back(expect_digit(t, page, d));
  endtask

  task automatic wait_digit0();
    logic [3:0] prev;
    bit found;
    prev  = fnd_com;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (fnd_com == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = fnd_com;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL sync_digit0 timeout: fnd_com=%b required=1110", fnd_com);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    i_time = '0;
    sw0    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fnd_com, fnd_data} !== 12'hFFF) begin
      errors++;
      $display("[TB] FAIL reset_hold: got com=%b data=%h, required com=1111 data=ff", fnd_com, fnd_data);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({fnd_com, fnd_data} !== 12'hFFF) begin
      errors++;
      $display("[TB] FAIL reset_blank_4: got com=%b data=%h, required com=1111 data=ff", fnd_com, fnd_data);
    end
    @(negedge clk);
    checks++;
    if ({fnd_com, fnd_data} !== {4'b1101, 8'hC0}) begin
      errors++;
      $display("[TB] FAIL first_digit_5: got com=%b data=%h, required com=1101 data=c0", fnd_com, fnd_data);
    end
  endtask

  task automatic test_sec_page();
    logic [11:0] expv;
    i_time = mk_time(0, 0, 42, 7);
    sw0    = 1'b0;
    push_frame(i_time, 1'b0);
    wait_digit0();
    wait_digit0();
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (4) @(negedge clk);
      expv = exp_q.pop_front();
      checks++;
      if ({fnd_com, fnd_data} !== expv) begin
        errors++;
        $display("[TB] FAIL sec_page d%0d: got com=%b data=%h, required com=%b data=%h",
                 d, fnd_com, fnd_data, expv[11:8], expv[7:0]);
      end
    end
  endtask

  task automatic test_hour_page();
    logic [11:0] expv;
    i_time = mk_time(23, 59, 0, 60);
    sw0    = 1'b1;
    push_frame(i_time, 1'b1);
    wait_digit0();
    wait_digit0();
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (4) @(negedge clk);
      expv = exp_q.pop_front();
      checks++;
      if ({fnd_com, fnd_data} !== expv) begin
        errors++;
        $display("[TB] FAIL hour_page d%0d: got com=%b data=%h, required com=%b data=%h",
                 d, fnd_com, fnd_data, expv[11:8], expv[7:0]);
      end
      if (d == 0) sw0 = 1'b0;
    end
    push_frame(i_time, 1'b0);
    wait_digit0();
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (4) @(negedge clk);
      expv = exp_q.pop_front();
      checks++;
      if ({fnd_com, fnd_data} !== expv) begin
        errors++;
        $display("[TB] FAIL page_toggle d%0d: got com=%b data=%h, required com=%b data=%h",
                 d, fnd_com, fnd_data, expv[11:8], expv[7:0]);
      end
    end
  endtask

  task automatic test_range();
    logic [11:0] expv;
    int msec_tab[2] = '{120, 50};
    sw0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_time = mk_time(0, 0, 42, msec_tab[k]);
      push_frame(i_time, 1'b0);
      wait_digit0();
      wait_digit0();
      for (int d = 0; d < 4; d++) begin
        if (d > 0) repeat (4) @(negedge clk);
        expv = exp_q.pop_front();
        checks++;
        if ({fnd_com, fnd_data} !== expv) begin
          errors++;
          $display("[TB] FAIL range msec=%0d d%0d: got com=%b data=%h, required com=%b data=%h",
                   msec_tab[k], d, fnd_com, fnd_data, expv[11:8], expv[7:0]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    i_time = mk_time(0, 0, 42, 7);
    sw0    = 1'b0;
    wait_digit0();
    repeat (8) @(negedge clk);
    checks++;
    if (fnd_com !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL mid_reset_pre: got com=%b, required com=1011", fnd_com);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({fnd_com, fnd_data} !== 12'hFFF) begin
      errors++;
      $display("[TB] FAIL mid_reset_async: got com=%b data=%h, required com=1111 data=ff", fnd_com, fnd_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({fnd_com, fnd_data} !== 12'hFFF) begin
      errors++;
      $display("[TB] FAIL restart_blank_4: got com=%b data=%h, required com=1111 data=ff", fnd_com, fnd_data);
    end
    @(negedge clk);
    checks++;
    if ({fnd_com, fnd_data} !== {4'b1101, 8'hC0}) begin
      errors++;
      $display("[TB] FAIL restart_digit_5: got com=%b data=%h, required com=1101 data=c0", fnd_com, fnd_data);
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] expv;
    i_time = mk_time(5, 0, 0, 60);
    sw0    = 1'b1;
    push_frame(i_time, 1'b1);
    wait_digit0();
    wait_digit0();
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (4) @(negedge clk);
      expv = exp_q.pop_front();
      checks++;
      if ({fnd_com, fnd_data} !== expv) begin
        errors++;
        $display("[TB] FAIL leading_zero d%0d: got com=%b data=%h, required com=%b data=%h",
                 d, fnd_com, fnd_data, expv[11:8], expv[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sec_page();
    test_hour_page();
    test_range();
    test_mid_reset();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
